// File: rtl/rf_pkg.sv
// Shared constants for the integer register file: default widths, the ABI
// register indices the core refers to by name, and the stack-top reset value.
package rf_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    // ABI register indices
    localparam int ZERO = 0;
    localparam int RA   = 1;
    localparam int SP   = 2;
    localparam int GP   = 3;

    localparam logic [31:0] SP_RESET_DEF = 32'h7FFF_EFFC;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the register file's write, read, scoreboard and debug signals.
// The pipeline side uses the master modport, the register file the slave.
interface regfile_scoreboard_if
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  busy_set;
    logic [ADDR_WIDTH-1:0] busy_addr;
    logic                  busy1;
    logic                  busy2;
    logic                  dbg_req;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_data;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
               dbg_req, dbg_addr,
        input  rdata1, rdata2, busy1, busy2, dbg_ack, dbg_data
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
               dbg_req, dbg_addr,
        output rdata1, rdata2, busy1, busy2, dbg_ack, dbg_data
    );

endinterface

// File: rtl/rf_reg_cell.sv
// One architectural register: load on enable, synchronous reset to a
// per-instance value so individual registers (e.g. sp) can start non-zero.
module rf_reg_cell
    import rf_pkg::*;
#(
    parameter int               WIDTH     = DATA_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register storage: reset has priority over the load enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 tied to zero, optional write-to-read bypass,
// a pending-write scoreboard for hazard detection and a registered debug
// read port with a one-cycle request/acknowledge handshake.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    SP_INDEX   = SP,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = DATA_WIDTH'(SP_RESET_DEF),
    parameter bit                    BYPASS     = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_data_q;
    logic [DATA_WIDTH-1:0] rdata1_c;
    logic [DATA_WIDTH-1:0] rdata2_c;
    logic                  wr_live;

    assign regs[0] = '0;

    genvar i;
    generate
        for (i = 1; i < DEPTH; i++) begin : g_cell
            rf_reg_cell #(
                .WIDTH     (DATA_WIDTH),
                .RESET_VAL ((i == SP_INDEX) ? SP_RESET : {DATA_WIDTH{1'b0}})
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .en  (bus.we && (bus.waddr == ADDR_WIDTH'(i))),
                .d   (bus.wdata),
                .q   (regs[i])
            );
        end
    endgenerate

    // A write that actually lands somewhere (x0 writes are dropped).
    assign wr_live = bus.we && (bus.waddr != '0);

    // Read ports: array lookup, overridden by same-cycle write data when bypass is built in.
    always_comb begin
        rdata1_c = regs[bus.raddr1];
        rdata2_c = regs[bus.raddr2];
        if (BYPASS && wr_live && (bus.waddr == bus.raddr1)) begin
            rdata1_c = bus.wdata;
        end
        if (BYPASS && wr_live && (bus.waddr == bus.raddr2)) begin
            rdata2_c = bus.wdata;
        end
    end

    assign bus.rdata1 = rdata1_c;
    assign bus.rdata2 = rdata2_c;

    // Scoreboard next state: retire clears first so a same-index issue re-marks it.
    always_comb begin
        busy_d = busy_q;
        if (bus.we) begin
            busy_d[bus.waddr] = 1'b0;
        end
        if (bus.busy_set && (bus.busy_addr != '0)) begin
            busy_d[bus.busy_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard flags read the registered vector only; the data bypass covers
    // a destination being retired in the same cycle it is read.
    assign bus.busy1 = busy_q[bus.raddr1];
    assign bus.busy2 = busy_q[bus.raddr2];

    // Debug port: capture pre-write contents on request, ack one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            dbg_ack_q <= bus.dbg_req;
            if (bus.dbg_req) begin
                dbg_data_q <= regs[bus.dbg_addr];
            end
        end
    end

    assign bus.dbg_ack  = dbg_ack_q;
    assign bus.dbg_data = dbg_data_q;

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the RISC-V core: one write port, two combinational read ports with optional write-to-read bypass, and x0 hardwired to zero. Every register has a parameter-selected reset value, so x2 (sp) comes out of reset at the stack top. An integrated pending-write scoreboard drives hazard/stall detection in the pipeline. A registered debug read port, with a request/acknowledge handshake, feeds the debug/trace unit.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, index width; depth = 2**ADDR_WIDTH
- SP_INDEX, 2, index of the stack-pointer register
- SP_RESET, 32'h7FFF_EFFC, reset value of register SP_INDEX; all other registers reset to 0
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable
- waddr  in  ADDR_WIDTH  write index
- wdata  in  DATA_WIDTH  write data
- raddr1, raddr2  in  ADDR_WIDTH  read indices (rs1, rs2)
- rdata1, rdata2  out  DATA_WIDTH  read data, combinational
- busy_set  in  1  an issued instruction will write busy_addr
- busy_addr  in  ADDR_WIDTH  destination marked pending
- busy1, busy2  out  1  raddr1/raddr2 has a pending write, combinational
- dbg_req  in  1  debug read request
- dbg_addr  in  ADDR_WIDTH  debug read index
- dbg_ack  out  1  debug data valid, one-cycle pulse
- dbg_data  out  DATA_WIDTH  debug read data, held until the next ack

## Operation
- Write:
  - we=1 and waddr!=0: reg[waddr] <= wdata at the edge.
  - Writes to index 0 are discarded; reg[0] always reads 0.
- Read: rdata = reg[raddr], or 0 when raddr=0.
  - If BYPASS=1, we=1, waddr==raddr and waddr!=0, then rdata = wdata in the same cycle.
- Scoreboard: busy vector of 2**ADDR_WIDTH bits.
  - Set: busy_set=1 and busy_addr!=0 sets bit[busy_addr].
  - Clear: we=1 clears bit[waddr].
  - Same index set and cleared in one cycle: set wins (the newer instruction owns the register).
  - Bit 0 is constantly 0.
- busy outputs: busy1 = bit[raddr1], busy2 = bit[raddr2], with no bypass. A bit being cleared this cycle still reads 1; the data bypass covers that case.
- Debug port: dbg_req=1 samples dbg_addr and the current (pre-write) register contents.
  - Next cycle: dbg_ack=1 and dbg_data = sampled value.
  - Back-to-back requests give back-to-back acks.
  - dbg_data holds when there is no ack.
- Reset (rst=1, any cycle, including mid-operation):
  - All registers go to their reset values: reg[SP_INDEX]=SP_RESET, others 0.
  - busy cleared to all 0; dbg_ack=0; dbg_data=0.
  - A dbg_req in the reset cycle is dropped.
  - Writes and busy_set in the reset cycle are ignored.

## Timing
- Write to visible (no bypass): 1 cycle. With BYPASS=1: 0 cycles.
- busy_set to busy visible: 1 cycle. Write clearing busy: visible 1 cycle later.
- dbg_req to dbg_ack: exactly 1 cycle; throughput 1 request per cycle.
- Outputs during and after reset:
  - rdata/busy reflect the reset state one cycle after the rst edge.
  - dbg_ack=0 and dbg_data=0 in the cycle after reset.
- rdata/busy paths are purely combinational from the raddr and write inputs.

## Structure
- Package rf_pkg:
  - ABI index constants (ZERO=0, RA=1, SP=2, GP=3).
  - Default SP_RESET value 32'h7FFF_EFFC.
  - DATA_WIDTH/ADDR_WIDTH defaults.
- Sub-module rf_reg_cell: one register with enable, synchronous reset, and a per-instance reset value. Instantiated for indices 1 to depth-1 in a generate loop; index 0 is a constant.
- The scoreboard and debug port live in the top module.

## Test plan
- Reset values: assert rst, read all indices -> x2=32'h7FFF_EFFC, all others 0, busy all 0, dbg_ack=0.
- Write/read:
  - Write 32'hDEAD_BEEF to x5, read next cycle -> 32'hDEAD_BEEF.
  - Write 32'h1234 to x0 -> reads 0.
- Bypass: same cycle we=1, waddr=7, wdata=32'hA5A5_A5A5, raddr1=7 -> rdata1=32'hA5A5_A5A5 when BYPASS=1, old value when BYPASS=0.
- Scoreboard:
  - busy_set x10 -> busy1=1 next cycle for raddr1=10.
  - Write x10 -> busy1=0 the following cycle.
  - Simultaneous set and write of x10 -> busy stays 1.
  - busy_set x0 -> busy stays 0.
- Debug: dbg_req on x2, then x5, on consecutive cycles -> dbg_ack high for 2 cycles with 32'h7FFF_EFFC then x5's value. A write to x5 in the same cycle as its request returns the old value.
- Mid-operation reset: x3 written, x4 busy, dbg_req pending, then rst -> next cycle x3=0, x2=SP_RESET, busy4=0, dbg_ack=0.
